// File: rtl/clk_div_if.sv
// Control/status bundle of the programmable clock divider.
interface clk_div_if #(
  parameter int unsigned CNT_W = 8
) ();
  logic             en;
  logic [CNT_W-1:0] div_ratio;
  logic             load;
  logic             clk_out;
  logic             tick;
  logic [CNT_W-1:0] cur_div;
  logic             load_pend;

  modport master (
    output en, div_ratio, load,
    input  clk_out, tick, cur_div, load_pend
  );

  modport slave (
    input  en, div_ratio, load,
    output clk_out, tick, cur_div, load_pend
  );
endinterface

// File: rtl/clk_div_prog.sv
// Runtime-programmable 50% duty-cycle integer clock divider with glitch-free
// ratio changes at period boundaries, per-period tick and clean stop.
module clk_div_prog #(
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned DEFAULT_DIV = 4
) (
  input logic     clk4,
  input logic     rst_n,
  clk_div_if.slave bus
);

  localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] MIN_DIV = CNT_W'(2);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cur_div_q, cur_div_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic             pend_v_q, pend_v_d;
  logic             p_q, p_d;
  logic             tick_q, tick_d;
  logic             odd_q, odd_d;
  logic             n_q;

  logic [CNT_W-1:0] ratio_san;
  logic [CNT_W-1:0] half;
  logic             boundary;

  assign ratio_san = (bus.div_ratio < MIN_DIV) ? MIN_DIV : bus.div_ratio;
  assign half      = cur_div_q >> 1;
  assign boundary  = (cnt_q == (cur_div_q - CNT_W'(1)));

  // Next-state and waveform decode
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cur_div_d = cur_div_q;
    pend_d    = pend_q;
    pend_v_d  = pend_v_q;
    p_d       = 1'b0;
    tick_d    = 1'b0;
    odd_d     = odd_q;

    case (state_q)
      S_IDLE: begin
        // Stopped: any waiting or newly loaded ratio takes effect immediately
        pend_v_d = 1'b0;
        if (pend_v_q) cur_div_d = pend_q;
        if (bus.load) begin
          cur_div_d = ratio_san;
          pend_d    = ratio_san;
        end
        if (bus.en) begin
          state_d = S_RUN;
          p_d     = 1'b1;
          tick_d  = 1'b1;
          cnt_d   = CNT_W'(1);
          odd_d   = cur_div_d[0];
        end
      end

      S_RUN: begin
        p_d = (cnt_q < half);
        if (bus.load) begin
          pend_d   = ratio_san;
          pend_v_d = 1'b1;
        end
        if (boundary) begin
          cnt_d = '0;
          if (pend_v_q) cur_div_d = pend_q;
          // A load coinciding with the boundary waits for the next one
          pend_v_d = bus.load;
          if (!bus.en) state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        // Odd-extension flag only changes as p_q rises, when n_q is already low
        if (cnt_q == '0) begin
          tick_d = 1'b1;
          odd_d  = cur_div_q[0];
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk4) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      cur_div_q <= DEF_DIV;
      pend_q    <= DEF_DIV;
      pend_v_q  <= 1'b0;
      p_q       <= 1'b0;
      tick_q    <= 1'b0;
      odd_q     <= DEF_DIV[0];
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cur_div_q <= cur_div_d;
      pend_q    <= pend_d;
      pend_v_q  <= pend_v_d;
      p_q       <= p_d;
      tick_q    <= tick_d;
      odd_q     <= odd_d;
    end
  end

  // Half-cycle stretch of the high phase for odd ratios
  always_ff @(negedge clk4) begin
    n_q <= p_q;
  end

  assign bus.clk_out   = p_q | (n_q & odd_q);
  assign bus.tick      = tick_q;
  assign bus.cur_div   = cur_div_q;
  assign bus.load_pend = pend_v_q;

endmodule
